inj_gate_seq: RTL and testbench

//  Sequencer for charge-injection bursts with TDC gating. Per shot: open GATE, wait, pulse INJECTION, hold GATE, close, pause; repeat N times.

---
 rtl/inj_gate_seq_pkg.sv | 41 ++++
 rtl/inj_gate_seq_phase_cnt.sv | 34 +++
 rtl/inj_gate_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_inj_gate_seq.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/inj_gate_seq_pkg.sv
// Shared types and constants for the injection/gate burst sequencer.
package inj_gate_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_THROTTLE = 3'd1,
      ST_ARM      = 3'd2,
      ST_PRE      = 3'd3,
      ST_INJ      = 3'd4,
      ST_POST     = 3'd5,
      ST_PAUSE    = 3'd6,
      ST_FIN      = 3'd7
   } seq_state_e;

   localparam logic [3:0] REG_SOFT_RST  = 4'd0;
   localparam logic [3:0] REG_START     = 4'd1;
   localparam logic [3:0] REG_VERSION   = 4'd2;
   localparam logic [3:0] REG_DELAY_LO  = 4'd3;
   localparam logic [3:0] REG_DELAY_HI  = 4'd4;
   localparam logic [3:0] REG_WIDTH_LO  = 4'd5;
   localparam logic [3:0] REG_WIDTH_HI  = 4'd6;
   localparam logic [3:0] REG_HOLD_LO   = 4'd7;
   localparam logic [3:0] REG_HOLD_HI   = 4'd8;
   localparam logic [3:0] REG_REPEAT_LO = 4'd9;
   localparam logic [3:0] REG_REPEAT_HI = 4'd10;
   localparam logic [3:0] REG_PAUSE_LO  = 4'd11;
   localparam logic [3:0] REG_PAUSE_HI  = 4'd12;
   localparam logic [3:0] REG_CONF      = 4'd13;
   localparam logic [3:0] REG_SHOT_LO   = 4'd14;
   localparam logic [3:0] REG_SHOT_HI   = 4'd15;

   localparam int CONF_EN_THROTTLE  = 0;
   localparam int CONF_EN_GRAY_RST  = 1;
   localparam int CONF_EN_EXT_START = 2;

   // Counter preload for an N-cycle phase; a programmed 0 still lasts one cycle.
   function automatic logic [15:0] phase_load(input logic [15:0] n);
      return (n == 16'd0) ? 16'd0 : n - 16'd1;
   endfunction

endpackage

// File: rtl/inj_gate_seq_phase_cnt.sv
// Loadable 16-bit down-counter shared by every timed phase of the sequencer.
module inj_gate_seq_phase_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   output logic        zero
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Load wins; otherwise count down and park at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != 16'd0) begin
         cnt_d = cnt_q - 16'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/inj_gate_seq.sv
// Charge-injection burst sequencer with TDC gate window and 8-bit bus register block.
//
// state    | meaning
// IDLE     | waiting for START write or EXT_START edge
// THROTTLE | holding off between shots while readout FIFO is near full
// ARM      | one cycle before the gate opens; gray reset pulse
// PRE      | gate open, waiting DELAY cycles before injection
// INJ      | gate open, injection pulse for WIDTH cycles
// POST     | gate open for HOLD cycles after injection
// PAUSE    | all outputs low for PAUSE cycles between shots
// FIN      | run complete, DONE set on exit
module inj_gate_seq
   import inj_gate_seq_pkg::*;
#(
   parameter logic [15:0] BASEADDR = 16'h0000,
   parameter logic [15:0] HIGHADDR = 16'h0000,
   parameter logic [7:0]  VERSION  = 8'd1
) (
   input  logic        BUS_CLK,
   input  logic        BUS_RST,
   input  logic [15:0] BUS_ADD,
   inout  wire  [7:0]  BUS_DATA,
   input  logic        BUS_RD,
   input  logic        BUS_WR,
   input  logic        EXT_START,
   input  logic        FIFO_NEAR_FULL,
   output logic        GATE,
   output logic        INJECTION,
   output logic        RST_GRAY,
   output logic        BUSY,
   output logic        DONE
);

   localparam logic [16:0] SPAN = {1'b0, HIGHADDR - BASEADDR} + 17'd1;

   logic [15:0] offset;
   logic [3:0]  reg_addr;
   logic        reg_hit;
   logic        wr_en;
   logic        soft_rst;
   logic        start_wr;
   logic        ext_rise;
   logic        start_req;

   logic [15:0] cfg_delay_q, cfg_width_q, cfg_hold_q, cfg_repeat_q, cfg_pause_q;
   logic [7:0]  cfg_conf_q;

   logic [15:0] w_delay_q, w_width_q, w_hold_q, w_repeat_q, w_pause_q;
   logic        w_thr_q, w_gray_q;

   seq_state_e  state_q, state_d;
   logic [15:0] shot_q, shot_d;
   logic        done_q, done_d;
   logic        gate_q, inj_q, rst_gray_q, busy_q, ext_q;

   logic        cnt_load;
   logic [15:0] cnt_val;
   logic        cnt_zero;

   logic [7:0]  rdata_q, rdata_d;
   logic        rd_vld_q;

   // Address decode: offset wraps large when below BASEADDR so one compare covers both ends.
   assign offset    = BUS_ADD - BASEADDR;
   assign reg_addr  = offset[3:0];
   assign reg_hit   = ({1'b0, offset} < SPAN) && (offset[15:4] == 12'd0);
   assign wr_en     = BUS_WR && reg_hit;
   assign soft_rst  = wr_en && (reg_addr == REG_SOFT_RST);
   assign start_wr  = wr_en && (reg_addr == REG_START) && BUS_DATA[0];
   assign ext_rise  = EXT_START && !ext_q;
   assign start_req = start_wr || (cfg_conf_q[CONF_EN_EXT_START] && ext_rise);

   // Configuration registers; only the bus reset clears them.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         cfg_delay_q  <= 16'd0;
         cfg_width_q  <= 16'd0;
         cfg_hold_q   <= 16'd0;
         cfg_repeat_q <= 16'd0;
         cfg_pause_q  <= 16'd0;
         cfg_conf_q   <= 8'd0;
      end else if (wr_en) begin
         case (reg_addr)
            REG_DELAY_LO:  cfg_delay_q[7:0]   <= BUS_DATA;
            REG_DELAY_HI:  cfg_delay_q[15:8]  <= BUS_DATA;
            REG_WIDTH_LO:  cfg_width_q[7:0]   <= BUS_DATA;
            REG_WIDTH_HI:  cfg_width_q[15:8]  <= BUS_DATA;
            REG_HOLD_LO:   cfg_hold_q[7:0]    <= BUS_DATA;
            REG_HOLD_HI:   cfg_hold_q[15:8]   <= BUS_DATA;
            REG_REPEAT_LO: cfg_repeat_q[7:0]  <= BUS_DATA;
            REG_REPEAT_HI: cfg_repeat_q[15:8] <= BUS_DATA;
            REG_PAUSE_LO:  cfg_pause_q[7:0]   <= BUS_DATA;
            REG_PAUSE_HI:  cfg_pause_q[15:8]  <= BUS_DATA;
            REG_CONF:      cfg_conf_q         <= BUS_DATA;
            default:       ;
         endcase
      end
   end

   // Read mux, registered below so data appears the cycle after BUS_RD.
   always_comb begin
      rdata_d = 8'h00;
      case (reg_addr)
         REG_START:     rdata_d = {6'b0, busy_q, done_q};
         REG_VERSION:   rdata_d = VERSION;
         REG_DELAY_LO:  rdata_d = cfg_delay_q[7:0];
         REG_DELAY_HI:  rdata_d = cfg_delay_q[15:8];
         REG_WIDTH_LO:  rdata_d = cfg_width_q[7:0];
         REG_WIDTH_HI:  rdata_d = cfg_width_q[15:8];
         REG_HOLD_LO:   rdata_d = cfg_hold_q[7:0];
         REG_HOLD_HI:   rdata_d = cfg_hold_q[15:8];
         REG_REPEAT_LO: rdata_d = cfg_repeat_q[7:0];
         REG_REPEAT_HI: rdata_d = cfg_repeat_q[15:8];
         REG_PAUSE_LO:  rdata_d = cfg_pause_q[7:0];
         REG_PAUSE_HI:  rdata_d = cfg_pause_q[15:8];
         REG_CONF:      rdata_d = cfg_conf_q;
         REG_SHOT_LO:   rdata_d = shot_q[7:0];
         REG_SHOT_HI:   rdata_d = shot_q[15:8];
         default:       rdata_d = 8'h00;
      endcase
   end

   // Registered read data and bus-drive enable.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         rdata_q  <= 8'h00;
         rd_vld_q <= 1'b0;
      end else begin
         rdata_q  <= rdata_d;
         rd_vld_q <= BUS_RD && reg_hit;
      end
   end

   assign BUS_DATA = rd_vld_q ? rdata_q : 8'hzz;

   // Next-state logic; the phase counter is loaded on entry to each timed phase.
   always_comb begin
      state_d  = state_q;
      shot_d   = shot_q;
      done_d   = done_q;
      cnt_load = 1'b0;
      cnt_val  = 16'd0;
      case (state_q)
         ST_IDLE: begin
            if (start_req) begin
               state_d = ST_THROTTLE;
               shot_d  = 16'd0;
               done_d  = 1'b0;
            end
         end
         ST_THROTTLE: begin
            if (!(w_thr_q && FIFO_NEAR_FULL)) state_d = ST_ARM;
         end
         ST_ARM: begin
            state_d  = ST_PRE;
            cnt_load = 1'b1;
            cnt_val  = phase_load(w_delay_q);
         end
         ST_PRE: begin
            if (cnt_zero) begin
               state_d  = ST_INJ;
               cnt_load = 1'b1;
               cnt_val  = phase_load(w_width_q);
            end
         end
         ST_INJ: begin
            if (cnt_zero) begin
               state_d  = ST_POST;
               cnt_load = 1'b1;
               cnt_val  = phase_load(w_hold_q);
            end
         end
         ST_POST: begin
            if (cnt_zero) begin
               state_d  = ST_PAUSE;
               cnt_load = 1'b1;
               cnt_val  = phase_load(w_pause_q);
               shot_d   = shot_q + 16'd1;
            end
         end
         ST_PAUSE: begin
            if (cnt_zero) begin
               state_d = ((w_repeat_q != 16'd0) && (shot_q == w_repeat_q)) ? ST_FIN : ST_THROTTLE;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (soft_rst) begin
         state_d  = ST_IDLE;
         shot_d   = 16'd0;
         done_d   = 1'b0;
         cnt_load = 1'b0;
      end
   end

   inj_gate_seq_phase_cnt u_phase_cnt (
      .clk      (BUS_CLK),
      .rst      (BUS_RST || soft_rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   // State, working copies and outputs; outputs are decoded from the next state so they are pure flops.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q    <= ST_IDLE;
         shot_q     <= 16'd0;
         done_q     <= 1'b0;
         gate_q     <= 1'b0;
         inj_q      <= 1'b0;
         rst_gray_q <= 1'b0;
         busy_q     <= 1'b0;
         ext_q      <= 1'b0;
         w_delay_q  <= 16'd0;
         w_width_q  <= 16'd0;
         w_hold_q   <= 16'd0;
         w_repeat_q <= 16'd0;
         w_pause_q  <= 16'd0;
         w_thr_q    <= 1'b0;
         w_gray_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         shot_q     <= shot_d;
         done_q     <= done_d;
         gate_q     <= (state_d == ST_PRE) || (state_d == ST_INJ) || (state_d == ST_POST);
         inj_q      <= (state_d == ST_INJ);
         rst_gray_q <= (state_d == ST_ARM) && w_gray_q;
         busy_q     <= (state_d != ST_IDLE);
         ext_q      <= EXT_START;
         if ((state_q == ST_IDLE) && start_req && !soft_rst) begin
            w_delay_q  <= cfg_delay_q;
            w_width_q  <= cfg_width_q;
            w_hold_q   <= cfg_hold_q;
            w_repeat_q <= cfg_repeat_q;
            w_pause_q  <= cfg_pause_q;
            w_thr_q    <= cfg_conf_q[CONF_EN_THROTTLE];
            w_gray_q   <= cfg_conf_q[CONF_EN_GRAY_RST];
         end
      end
   end

   assign GATE      = gate_q;
   assign INJECTION = inj_q;
   assign RST_GRAY  = rst_gray_q;
   assign BUSY      = busy_q;
   assign DONE      = done_q;

endmodule

// File: tb/tb_inj_gate_seq.sv
// Directed bench for the injection/gate burst sequencer.
module tb_inj_gate_seq;

   localparam logic [15:0] BASE = 16'h4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] add = 16'h0000;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [7:0]  dout = 8'h00;
   logic        doe = 1'b0;
   logic        ext = 1'b0;
   logic        fifo = 1'b0;
   wire  [7:0]  bus_data;
   logic        gate, inj, rst_gray, busy, done;

   int n_total = 0;
   int n_bad = 0;

   int gate_cyc, inj_cyc, gray_cyc, gate_rises, inj_first;
   int rise_at[4];
   int used;
   logic [7:0] rv;

   always #5 clk = ~clk;

   assign bus_data = doe ? dout : 8'hzz;

   inj_gate_seq #(
      .BASEADDR (BASE),
      .HIGHADDR (16'h400F),
      .VERSION  (8'd1)
   ) dut (
      .BUS_CLK        (clk),
      .BUS_RST        (rst),
      .BUS_ADD        (add),
      .BUS_DATA       (bus_data),
      .BUS_RD         (rd),
      .BUS_WR         (wr),
      .EXT_START      (ext),
      .FIFO_NEAR_FULL (fifo),
      .GATE           (gate),
      .INJECTION      (inj),
      .RST_GRAY       (rst_gray),
      .BUSY           (busy),
      .DONE           (done)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] off, input logic [7:0] d);
      add  = BASE + {12'd0, off};
      dout = d;
      doe  = 1'b1;
      wr   = 1'b1;
      tick();
      wr   = 1'b0;
      doe  = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] off, output logic [7:0] d);
      add = BASE + {12'd0, off};
      rd  = 1'b1;
      tick();
      rd  = 1'b0;
      d   = bus_data;
   endtask

   task automatic cfg_counts(input logic [15:0] dl, input logic [15:0] wd, input logic [15:0] hd,
                             input logic [15:0] ps, input logic [15:0] rp);
      bus_write(4'd3, dl[7:0]);  bus_write(4'd4, dl[15:8]);
      bus_write(4'd5, wd[7:0]);  bus_write(4'd6, wd[15:8]);
      bus_write(4'd7, hd[7:0]);  bus_write(4'd8, hd[15:8]);
      bus_write(4'd9, rp[7:0]);  bus_write(4'd10, rp[15:8]);
      bus_write(4'd11, ps[7:0]); bus_write(4'd12, ps[15:8]);
   endtask

   // Samples outputs each cycle until DONE; drives FIFO window and a one-cycle EXT_START at given cycles.
   task automatic observe(input int budget, input int fifo_on, input int fifo_off, input int ext_at,
                          output int n_used);
      logic gate_p, inj_p;
      gate_cyc = 0; inj_cyc = 0; gray_cyc = 0; gate_rises = 0; inj_first = -1;
      for (int k = 0; k < 4; k++) rise_at[k] = -1;
      gate_p = gate;
      inj_p  = inj;
      n_used = budget;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (gate) gate_cyc++;
         if (inj) inj_cyc++;
         if (rst_gray) gray_cyc++;
         if (gate && !gate_p) begin
            if (gate_rises < 4) rise_at[gate_rises] = c;
            gate_rises++;
         end
         if (inj && !inj_p && inj_first < 0) inj_first = c;
         gate_p = gate;
         inj_p  = inj;
         fifo   = (c >= fifo_on) && (c < fifo_off);
         ext    = (c == ext_at);
         if (done) begin
            n_used = c;
            break;
         end
      end
      fifo = 1'b0;
      ext  = 1'b0;
   endtask

   initial begin
      int n;
      logic p;

      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_gate", int'(gate), 0);
      chk("rst_inj", int'(inj), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      bus_read(4'd1, rv);  chk("rst_status", int'(rv), 0);
      bus_read(4'd14, rv); chk("rst_shot", int'(rv), 0);

      // 1: nominal two-shot run; DELAY rewrite while busy must not affect it
      cfg_counts(16'd3, 16'd2, 16'd4, 16'd5, 16'd2);
      bus_write(4'd13, 8'h00);
      bus_write(4'd1, 8'h01);
      chk("t1_busy", int'(busy), 1);
      bus_write(4'd3, 8'd7);
      observe(200, -1, -1, -1, used);
      chk("t1_len", used, 31);
      chk("t1_gate_rise", rise_at[0], 0);
      chk("t1_inj_ofs", inj_first - rise_at[0], 3);
      chk("t1_gate_cyc", gate_cyc, 18);
      chk("t1_inj_cyc", inj_cyc, 4);
      chk("t1_shots", gate_rises, 2);
      chk("t1_gray", gray_cyc, 0);
      bus_read(4'd14, rv); chk("t1_shot_lo", int'(rv), 2);
      bus_read(4'd15, rv); chk("t1_shot_hi", int'(rv), 0);
      bus_read(4'd1, rv);  chk("t1_status", int'(rv), 1);

      // 2: all counts zero, single shot
      cfg_counts(16'd0, 16'd0, 16'd0, 16'd0, 16'd1);
      bus_write(4'd1, 8'h01);
      chk("t2_done_clr", int'(done), 0);
      observe(100, -1, -1, -1, used);
      chk("t2_len", used, 6);
      chk("t2_gate_cyc", gate_cyc, 3);
      chk("t2_inj_cyc", inj_cyc, 1);
      chk("t2_inj_first", inj_first, 2);

      // 3: throttle between shots
      cfg_counts(16'd3, 16'd2, 16'd4, 16'd5, 16'd2);
      bus_write(4'd13, 8'h01);
      bus_write(4'd1, 8'h01);
      observe(300, 10, 30, -1, used);
      chk("t3_shot1_rise", rise_at[0], 1);
      chk("t3_shot2_rise", rise_at[1], 32);
      chk("t3_gate_cyc", gate_cyc, 18);
      chk("t3_len", used, 47);

      // 4: endless run, soft reset during injection of the third shot
      bus_write(4'd13, 8'h00);
      cfg_counts(16'd2, 16'd10, 16'd2, 16'd2, 16'd0);
      bus_write(4'd1, 8'h01);
      n = 0;
      p = inj;
      for (int i = 0; i < 300 && n < 3; i++) begin
         tick();
         if (inj && !p) n++;
         p = inj;
      end
      chk("t4_reach", n, 3);
      chk("t4_gate_pre", int'(gate), 1);
      bus_write(4'd0, 8'h5A);
      chk("t4_gate", int'(gate), 0);
      chk("t4_inj", int'(inj), 0);
      chk("t4_busy", int'(busy), 0);
      chk("t4_done", int'(done), 0);
      bus_read(4'd14, rv); chk("t4_shot", int'(rv), 0);
      bus_read(4'd3, rv);  chk("t4_cfg_kept", int'(rv), 2);

      // EXT_START ignored while disabled
      ext = 1'b1; tick(); ext = 1'b0; tick();
      chk("t5_ext_dis", int'(busy), 0);

      // 5: external start, pulse while busy ignored, gray reset per shot
      cfg_counts(16'd1, 16'd1, 16'd1, 16'd1, 16'd3);
      bus_write(4'd13, 8'h06);
      ext = 1'b1; tick(); ext = 1'b0;
      chk("t5_start1", int'(busy), 1);
      observe(100, -1, -1, 3, used);
      chk("t5_len1", used, 18);
      chk("t5_gray1", gray_cyc, 3);
      chk("t5_shots1", gate_rises, 3);
      chk("t5_gate_cyc1", gate_cyc, 9);
      ext = 1'b1; tick(); ext = 1'b0;
      chk("t5_start2", int'(busy), 1);
      chk("t5_done_clr", int'(done), 0);
      observe(100, -1, -1, -1, used);
      chk("t5_len2", used, 18);
      chk("t5_gray2", gray_cyc, 3);

      // 6: register readback
      for (int k = 3; k <= 13; k++) bus_write(4'(k), 8'(k * 17));
      for (int k = 3; k <= 13; k++) begin
         bus_read(4'(k), rv);
         chk($sformatf("t6_reg%0d", k), int'(rv), k * 17);
      end
      bus_read(4'd2, rv); chk("t6_version", int'(rv), 1);
      bus_read(4'd1, rv); chk("t6_status", int'(rv), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      bus_read(4'd5, rv); chk("t6_cfg_rst", int'(rv), 0);
      bus_read(4'd1, rv); chk("t6_status_rst", int'(rv), 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
